// File: rtl/fsrc_tx_sequencer.sv
// rtl/fsrc_tx_sequencer.sv - control sequencer for the TX fractional sample-rate converter
//
// Purpose: turns register start/stop/rate-change requests and an optional
// external trigger into the datapath control sequence: enable, accumulator
// preload, data-start pulse, beat-aligned rate update and timed drain.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cfg_start/cfg_stop     one-cycle start / stop requests
//   cfg_change_rate        one-cycle request to apply cfg_add_val
//   cfg_ext_trig_en        wait for an ext_trig rising edge before data start
//   cfg_conv_mask          converter mask, latched on an accepted start
//   cfg_add_val            accumulator increment
//   cfg_drain_cycles       extra cycles fsrc_stop is held before disable
//   ext_trig               external trigger level
//   in_valid/in_ready      datapath input handshake (monitored only)
//   fsrc_*                 registered datapath controls
//   conv_mask              active converter mask
//   accum_add_val          active accumulator increment
//   state                  current state (IDLE=0 PRELOAD=1 ARM=2 RUN=3 DRAIN=4)
//   beat_count             saturating count of accepted beats since start
//   start_ignored          sticky: start request seen outside IDLE
module fsrc_tx_sequencer #(
  parameter int ACCUM_WIDTH = 64,
  parameter int MAX_CONV    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic                   cfg_change_rate,
  input  logic                   cfg_ext_trig_en,
  input  logic [MAX_CONV-1:0]    cfg_conv_mask,
  input  logic [ACCUM_WIDTH-1:0] cfg_add_val,
  input  logic [7:0]             cfg_drain_cycles,
  input  logic                   ext_trig,
  input  logic                   in_valid,
  input  logic                   in_ready,
  output logic                   fsrc_en,
  output logic                   fsrc_accum_set,
  output logic                   fsrc_data_start,
  output logic                   fsrc_stop,
  output logic [MAX_CONV-1:0]    conv_mask,
  output logic [ACCUM_WIDTH-1:0] accum_add_val,
  output logic [2:0]             state,
  output logic [31:0]            beat_count,
  output logic                   start_ignored
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_ARM     = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             drain_q, drain_d;
  logic                   trig_q;
  logic                   pending_q, pending_d;
  logic [ACCUM_WIDTH-1:0] shadow_q, shadow_d;
  logic [ACCUM_WIDTH-1:0] accum_q, accum_d;
  logic [MAX_CONV-1:0]    mask_q, mask_d;
  logic [31:0]            beat_q, beat_d;
  logic                   ign_q, ign_d;
  logic                   en_q, set_q, dstart_q, stop_q;
  logic                   handshake, trig_rise;

  assign handshake = in_valid & in_ready;
  assign trig_rise = ext_trig & ~trig_q;

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    accum_d   = accum_q;
    mask_d    = mask_q;
    beat_d    = beat_q;
    ign_d     = ign_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start && !cfg_stop) begin
          state_d   = S_PRELOAD;
          mask_d    = cfg_conv_mask;
          accum_d   = cfg_add_val;
          beat_d    = '0;
          ign_d     = 1'b0;
          pending_d = 1'b0;
        end else if (cfg_change_rate) begin
          accum_d = cfg_add_val;
        end
      end
      S_PRELOAD: begin
        if (cfg_stop)             state_d = S_IDLE;
        else if (cfg_ext_trig_en) state_d = S_ARM;
        else                      state_d = S_RUN;
      end
      S_ARM: begin
        if (cfg_stop)       state_d = S_IDLE;
        else if (trig_rise) state_d = S_RUN;
      end
      S_RUN: begin
        if (handshake && beat_q != 32'hFFFF_FFFF) beat_d = beat_q + 32'd1;
        if (cfg_stop) begin
          state_d   = S_DRAIN;
          drain_d   = cfg_drain_cycles;
          pending_d = 1'b0;
        end else begin
          // The pending value is only consumed by a handshake after the
          // request cycle; a same-cycle request re-arms for the next beat.
          if (handshake && pending_q) begin
            accum_d   = shadow_q;
            pending_d = 1'b0;
          end
          if (cfg_change_rate) begin
            pending_d = 1'b1;
            shadow_d  = cfg_add_val;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 8'd0) state_d = S_IDLE;
        else                 drain_d = drain_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && cfg_start) ign_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      trig_q    <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      accum_q   <= '0;
      mask_q    <= '0;
      beat_q    <= '0;
      ign_q     <= 1'b0;
      en_q      <= 1'b0;
      set_q     <= 1'b0;
      dstart_q  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      trig_q    <= ext_trig;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      accum_q   <= accum_d;
      mask_q    <= mask_d;
      beat_q    <= beat_d;
      ign_q     <= ign_d;
      // Controls are decoded from the next state so they line up with it.
      en_q      <= (state_d != S_IDLE);
      set_q     <= (state_d == S_PRELOAD);
      dstart_q  <= (state_d == S_RUN) && (state_q != S_RUN);
      stop_q    <= (state_d == S_DRAIN);
    end
  end

  assign fsrc_en         = en_q;
  assign fsrc_accum_set  = set_q;
  assign fsrc_data_start = dstart_q;
  assign fsrc_stop       = stop_q;
  assign conv_mask       = mask_q;
  assign accum_add_val   = accum_q;
  assign state           = state_q;
  assign beat_count      = beat_q;
  assign start_ignored   = ign_q;

endmodule

// File: tb/tb_fsrc_tx_sequencer.sv
// tb/tb_fsrc_tx_sequencer.sv - self-checking bench for fsrc_tx_sequencer
module tb_fsrc_tx_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_change_rate = 1'b0;
  logic        cfg_ext_trig_en = 1'b0;
  logic [7:0]  cfg_conv_mask = '0;
  logic [63:0] cfg_add_val = '0;
  logic [7:0]  cfg_drain_cycles = '0;
  logic        ext_trig = 1'b0, in_valid = 1'b0, in_ready = 1'b0;
  logic        fsrc_en, fsrc_accum_set, fsrc_data_start, fsrc_stop;
  logic [7:0]  conv_mask;
  logic [63:0] accum_add_val;
  logic [2:0]  state;
  logic [31:0] beat_count;
  logic        start_ignored;

  int          checks = 0;
  int          errors = 0;

  logic [63:0] exp_accum;
  logic [31:0] exp_beats;
  logic [7:0]  exp_mask;

  fsrc_tx_sequencer #(.ACCUM_WIDTH(64), .MAX_CONV(8)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_change_rate(cfg_change_rate),
    .cfg_ext_trig_en(cfg_ext_trig_en), .cfg_conv_mask(cfg_conv_mask),
    .cfg_add_val(cfg_add_val), .cfg_drain_cycles(cfg_drain_cycles),
    .ext_trig(ext_trig), .in_valid(in_valid), .in_ready(in_ready),
    .fsrc_en(fsrc_en), .fsrc_accum_set(fsrc_accum_set),
    .fsrc_data_start(fsrc_data_start), .fsrc_stop(fsrc_stop),
    .conv_mask(conv_mask), .accum_add_val(accum_add_val), .state(state),
    .beat_count(beat_count), .start_ignored(start_ignored)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues an accepted start and walks to RUN (no external trigger).
  task automatic start_run(input logic [63:0] add, input logic [7:0] mask);
    cfg_ext_trig_en = 1'b0;
    cfg_add_val = add;
    cfg_conv_mask = mask;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_add_val = {$urandom, $urandom};
    cfg_conv_mask = 8'($urandom);
    step();
    exp_accum = add;
    exp_beats = 0;
    exp_mask = mask;
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL start_run_state got %0d want 3", state);
    end
  endtask

  task automatic stop_to_idle();
    cfg_drain_cycles = 8'd0;
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if ({fsrc_en, fsrc_accum_set, fsrc_data_start, fsrc_stop, start_ignored} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {fsrc_en, fsrc_accum_set, fsrc_data_start, fsrc_stop, start_ignored});
    end
    checks++;
    if (accum_add_val !== 64'd0 || conv_mask !== 8'd0) begin
      errors++;
      $display("FAIL reset_cfg got accum %h mask %h want 0", accum_add_val, conv_mask);
    end
    checks++;
    if (beat_count !== 32'd0) begin errors++; $display("FAIL reset_beats got %0d want 0", beat_count); end
  endtask

  task automatic test_start_no_trig();
    logic [7:0] mask;
    mask = 8'($urandom);
    cfg_ext_trig_en = 1'b0;
    cfg_add_val = 64'h1_0000_0000;
    cfg_conv_mask = mask;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_add_val = {$urandom, $urandom};
    checks++;
    if (state !== 3'd1 || fsrc_accum_set !== 1'b1 || fsrc_en !== 1'b1 || fsrc_data_start !== 1'b0) begin
      errors++;
      $display("FAIL preload got st %0d set %b en %b ds %b want 1 1 1 0",
               state, fsrc_accum_set, fsrc_en, fsrc_data_start);
    end
    checks++;
    if (conv_mask !== mask || accum_add_val !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL latch got mask %h accum %h want %h 100000000", conv_mask, accum_add_val, mask);
    end
    step();
    checks++;
    if (state !== 3'd3 || fsrc_data_start !== 1'b1 || fsrc_accum_set !== 1'b0) begin
      errors++;
      $display("FAIL run_entry got st %0d ds %b set %b want 3 1 0", state, fsrc_data_start, fsrc_accum_set);
    end
    step();
    checks++;
    if (state !== 3'd3 || fsrc_data_start !== 1'b0 || accum_add_val !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL run_hold got st %0d ds %b accum %h want 3 0 100000000",
               state, fsrc_data_start, accum_add_val);
    end
    exp_accum = 64'h1_0000_0000;
    exp_beats = 0;
  endtask

  task automatic test_rate_change();
    for (int b = 1; b <= 10; b++) begin
      in_valid = 1'b1;
      in_ready = 1'b1;
      if (b == 5) begin
        checks++;
        if (accum_add_val !== 64'h1_0000_0000) begin
          errors++;
          $display("FAIL rate_early got %h want 100000000", accum_add_val);
        end
      end
      step();
      in_valid = 1'b0;
      in_ready = 1'b0;
      if (b == 5) begin
        checks++;
        if (accum_add_val !== 64'h2000) begin
          errors++;
          $display("FAIL rate_apply got %h want 2000", accum_add_val);
        end
      end
      if (b == 4) begin
        cfg_change_rate = 1'b1;
        cfg_add_val = 64'h2000;
        step();
        cfg_change_rate = 1'b0;
        cfg_add_val = {$urandom, $urandom};
      end
      repeat ($urandom_range(0, 2)) step();
    end
    checks++;
    if (beat_count !== 32'd10) begin errors++; $display("FAIL beats10 got %0d want 10", beat_count); end
    exp_accum = 64'h2000;
    exp_beats = 10;
  endtask

  // Reference: a rate request is applied by the first handshake in a later
  // cycle; the newest request at that moment wins.
  task automatic test_rate_random(input int ncyc);
    logic        pend;
    logic [63:0] pend_val;
    logic        hs, cr;
    logic [63:0] val;
    int          bad;
    pend = 1'b0;
    pend_val = '0;
    bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = 1'($urandom_range(0, 1));
      cr = ($urandom_range(0, 5) == 0);
      val = {$urandom, $urandom};
      cfg_change_rate = cr;
      cfg_add_val = val;
      hs = in_valid & in_ready;
      step();
      if (hs && pend) begin exp_accum = pend_val; pend = 1'b0; end
      if (cr) begin pend = 1'b1; pend_val = val; end
      if (hs) exp_beats = exp_beats + 1;
      checks++;
      if (accum_add_val !== exp_accum || beat_count !== exp_beats) begin
        errors++;
        if (bad < 5)
          $display("FAIL rate_rand c%0d got accum %h beats %0d want %h %0d",
                   c, accum_add_val, beat_count, exp_accum, exp_beats);
        bad++;
      end
    end
    in_valid = 1'b0;
    in_ready = 1'b0;
    cfg_change_rate = 1'b0;
  endtask

  task automatic test_stop_drain(input logic [7:0] drain);
    int n;
    int en_bad;
    int st_bad;
    n = 0;
    en_bad = 0;
    st_bad = 0;
    cfg_drain_cycles = drain;
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    cfg_drain_cycles = 8'($urandom);
    for (int k = 0; k < 300; k++) begin
      if (!fsrc_stop) break;
      n++;
      if (fsrc_en !== 1'b1) en_bad++;
      if (state !== 3'd4) st_bad++;
      cfg_start = (k == 0);
      step();
    end
    cfg_start = 1'b0;
    checks++;
    if (n != int'(drain) + 1) begin
      errors++;
      $display("FAIL drain_len got %0d want %0d", n, int'(drain) + 1);
    end
    checks++;
    if (en_bad != 0 || st_bad != 0) begin
      errors++;
      $display("FAIL drain_hold got en_bad %0d st_bad %0d want 0 0", en_bad, st_bad);
    end
    checks++;
    if (state !== 3'd0 || fsrc_en !== 1'b0 || fsrc_stop !== 1'b0) begin
      errors++;
      $display("FAIL drain_end got st %0d en %b stop %b want 0 0 0", state, fsrc_en, fsrc_stop);
    end
    checks++;
    if (start_ignored !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored got %b want 1", start_ignored);
    end
  endtask

  task automatic test_start_stop_idle();
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    checks++;
    if (state !== 3'd0 || fsrc_en !== 1'b0 || fsrc_accum_set !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle got st %0d en %b set %b want 0 0 0", state, fsrc_en, fsrc_accum_set);
    end
  endtask

  task automatic test_change_rate_idle();
    logic [63:0] v;
    v = {$urandom, $urandom};
    cfg_add_val = v;
    cfg_change_rate = 1'b1;
    step();
    cfg_change_rate = 1'b0;
    cfg_add_val = '0;
    checks++;
    if (accum_add_val !== v || state !== 3'd0) begin
      errors++;
      $display("FAIL idle_rate got %h st %0d want %h 0", accum_add_val, state, v);
    end
  endtask

  task automatic test_ext_trig();
    int bad;
    bad = 0;
    cfg_ext_trig_en = 1'b1;
    ext_trig = 1'b1;
    cfg_add_val = {$urandom, $urandom};
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL trig_preload got %0d want 1", state); end
    step();
    repeat ($urandom_range(2, 5)) begin
      if (state !== 3'd2 || fsrc_data_start !== 1'b0 || fsrc_en !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trig_held got %0d bad cycles want 0", bad); end
    ext_trig = 1'b0;
    step();
    repeat ($urandom_range(0, 3)) step();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL trig_wait got %0d want 2", state); end
    ext_trig = 1'b1;
    step();
    checks++;
    if (state !== 3'd3 || fsrc_data_start !== 1'b1) begin
      errors++;
      $display("FAIL trig_start got st %0d ds %b want 3 1", state, fsrc_data_start);
    end
    ext_trig = 1'b0;
    stop_to_idle();
  endtask

  task automatic test_stop_in_arm();
    cfg_ext_trig_en = 1'b1;
    ext_trig = 1'b0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL arm_entry got %0d want 2", state); end
    cfg_stop = 1'b1;
    ext_trig = 1'b1;
    step();
    cfg_stop = 1'b0;
    ext_trig = 1'b0;
    checks++;
    if (state !== 3'd0 || fsrc_stop !== 1'b0 || fsrc_en !== 1'b0 || fsrc_data_start !== 1'b0) begin
      errors++;
      $display("FAIL arm_stop got st %0d stop %b en %b ds %b want 0 0 0 0",
               state, fsrc_stop, fsrc_en, fsrc_data_start);
    end
    cfg_ext_trig_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      start_run({$urandom, $urandom}, 8'($urandom));
      checks++;
      if (beat_count !== 32'd0 || start_ignored !== 1'b0 || conv_mask !== exp_mask) begin
        errors++;
        $display("FAIL b2b_start got beats %0d ign %b mask %h want 0 0 %h",
                 beat_count, start_ignored, conv_mask, exp_mask);
      end
      test_rate_random(40);
      test_stop_drain(8'($urandom_range(0, 6)));
    end
  endtask

  task automatic test_reset_mid_run();
    start_run({$urandom, $urandom}, 8'($urandom | 1));
    in_valid = 1'b1;
    in_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    in_ready = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks++;
    if (state !== 3'd0 || {fsrc_en, fsrc_accum_set, fsrc_data_start, fsrc_stop, start_ignored} !== 5'b0
        || accum_add_val !== 64'd0 || conv_mask !== 8'd0 || beat_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got st %0d accum %h mask %h beats %0d want all 0",
               state, accum_add_val, conv_mask, beat_count);
    end
  endtask

  initial begin
    test_reset();
    test_start_no_trig();
    test_rate_change();
    test_rate_random(100);
    test_stop_drain(8'd3);
    test_start_stop_idle();
    test_change_rate_idle();
    test_ext_trig();
    test_stop_in_arm();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsrc_tx_sequencer.md
# fsrc_tx_sequencer

Control sequencer for the TX fractional sample-rate converter datapath (`tx_fsrc`). It sits between the register map and the converter datapath. It turns register-level start, stop and rate-change requests and an optional external trigger into a cycle-exact control sequence for the datapath:

- enable
- accumulator preload
- data-start pulse
- rate update at a beat boundary
- timed stop/drain

## Interface

Parameters:

- `ACCUM_WIDTH`, 64: width of the phase accumulator increment.
- `MAX_CONV`, 8: number of converter lanes; sets the conv_mask width.

Ports:

- `clk` in 1: single clock for all logic.
- `resetn` in 1: synchronous, active-low reset.
- `cfg_start` in 1: one-cycle start request.
- `cfg_stop` in 1: one-cycle stop request.
- `cfg_change_rate` in 1: one-cycle request to apply `cfg_add_val` while running.
- `cfg_ext_trig_en` in 1: when 1, wait for an `ext_trig` rising edge before data start.
- `cfg_conv_mask` in MAX_CONV: converter enable mask, latched on an accepted start.
- `cfg_add_val` in ACCUM_WIDTH: accumulator increment.
- `cfg_drain_cycles` in 8: number of extra cycles `fsrc_stop` is held before disable.
- `ext_trig` in 1: external start trigger (level; edge-detected internally).
- `in_valid` in 1: datapath input valid (monitored only).
- `in_ready` in 1: datapath input ready (monitored only).
- `fsrc_en` out 1: datapath enable.
- `fsrc_accum_set` out 1: one-cycle accumulator preload pulse.
- `fsrc_data_start` out 1: one-cycle data start pulse.
- `fsrc_stop` out 1: datapath stop request.
- `conv_mask` out MAX_CONV: active converter mask.
- `accum_add_val` out ACCUM_WIDTH: active accumulator increment.
- `state` out 3: current state encoding, for status readback.
- `beat_count` out 32: accepted input beats since the last start; saturates at `32'hFFFF_FFFF`.
- `start_ignored` out 1: sticky flag, set by a start request that arrives outside IDLE.

## Operation

- States and encodings: IDLE=0, PRELOAD=1, ARM=2, RUN=3, DRAIN=4. All outputs are registered.
- Reset values: state=IDLE; every output is 0, including `conv_mask`, `accum_add_val`, `beat_count` and `start_ignored`; the pending-rate flag and the trigger edge register are cleared.

IDLE:
- `cfg_start` and not `cfg_stop` → PRELOAD. On this transition, latch `conv_mask`←`cfg_conv_mask` and `accum_add_val`←`cfg_add_val`, clear `beat_count` and `start_ignored`.
- `cfg_start` and `cfg_stop` together: stop wins and the state stays IDLE.
- `cfg_change_rate` in IDLE: `accum_add_val`←`cfg_add_val` on the next cycle.

PRELOAD:
- Lasts exactly 1 cycle, with `fsrc_en`=1 and `fsrc_accum_set`=1.
- Next state is ARM if `cfg_ext_trig_en`=1, otherwise RUN.
- `cfg_stop` in PRELOAD → IDLE.

ARM:
- `fsrc_en`=1; waits for a rising edge (`ext_trig`=1 with the previous-cycle sample 0) → RUN.
- The edge register samples every cycle in every state, so a trigger that is already high on ARM entry does not start the datapath.
- `cfg_stop` → IDLE; stop wins over a simultaneous edge.

RUN:
- `fsrc_data_start`=1 on the first RUN cycle only.
- `beat_count` increments on each cycle with `in_valid`&`in_ready`.
- `cfg_change_rate` sets the pending flag and captures `cfg_add_val` into a shadow register; a later request overwrites the shadow.
- On the first handshake cycle with pending=1: `accum_add_val`←shadow on the next cycle and pending clears. A request and a handshake in the same cycle take effect at the next handshake, not the current one.
- `cfg_stop` → DRAIN, discarding any pending rate change.

DRAIN:
- `fsrc_stop`=1 and `fsrc_en`=1. A counter loads `cfg_drain_cycles` on entry and decrements each cycle; at 0 → IDLE.
- DRAIN therefore lasts `cfg_drain_cycles`+1 cycles.
- On IDLE entry, `fsrc_en`=0 and `fsrc_stop`=0.
- `cfg_start` in DRAIN is ignored.

Any state other than IDLE: `cfg_start` sets `start_ignored` and has no other effect.

Reset mid-operation: on the next edge, return to IDLE with reset values. There is no drain.

## Timing

- `cfg_start` at cycle N (IDLE) → PRELOAD at N+1, with `fsrc_en` and `fsrc_accum_set` high at N+1.
- Without external trigger: RUN at N+2, with `fsrc_data_start` high at N+2 only.
- With external trigger: `ext_trig` rising at cycle M during ARM → RUN and `fsrc_data_start` at M+1.
- Rate change: handshake at cycle H with pending=1 → new `accum_add_val` visible at H+1.
- Stop: `cfg_stop` at cycle S in RUN → DRAIN at S+1 → IDLE at S+2+`cfg_drain_cycles`.
- `conv_mask` is constant from PRELOAD until the next accepted start.

## Test plan

- Reset, then `cfg_start` with `cfg_ext_trig_en`=0 and `cfg_add_val`=0x1_0000_0000 → `fsrc_accum_set` at N+1, `fsrc_data_start` at N+2, `accum_add_val`=0x1_0000_0000, `state`=3.
- `cfg_ext_trig_en`=1 and `ext_trig` held high before start → stays ARM; drop `ext_trig`, raise it at cycle M → `fsrc_data_start` at M+1.
- RUN with 10 handshakes, `cfg_change_rate` with value 0x2000 between beats 4 and 5 → `accum_add_val` changes 1 cycle after beat 5; `beat_count`=10.
- `cfg_stop` in RUN with `cfg_drain_cycles`=3 → `fsrc_stop` high for exactly 4 cycles; `fsrc_en` low at S+5. A `cfg_start` during drain → `start_ignored`=1 and state unchanged.
- Simultaneous `cfg_start`+`cfg_stop` in IDLE → stays IDLE. `cfg_stop` in ARM → IDLE on the next cycle with no DRAIN.
- `resetn`=0 for 1 cycle during RUN → state=0 and all outputs 0 on the next cycle.
